// File: rtl/knn_panel_ctrl.sv
// Front-panel controller for the k-NN engine: debounces buttons, holds query and K selection,
// sequences the engine through a start/done handshake and shows class and latency on the LEDs.
module knn_panel_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned LAT_W           = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] switches,
   input  logic       btn_load_x,
   input  logic       btn_load_y,
   input  logic       btn_start,
   input  logic       btn_toggle_k,
   output logic [7:0] query_x,
   output logic [7:0] query_y,
   output logic       k_sel,
   output logic       eng_start,
   input  logic       eng_done,
   input  logic       eng_class,
   output logic       busy,
   output logic [7:0] leds
);

   localparam int unsigned NumBtn  = 4;
   localparam int unsigned BtnLdX  = 0;
   localparam int unsigned BtnLdY  = 1;
   localparam int unsigned BtnSt   = 2;
   localparam int unsigned BtnTgK  = 3;

   localparam logic [7:0]       DbMax  = 8'(DEBOUNCE_CYCLES);
   localparam logic [LAT_W-1:0] LatMax = '1;
   localparam logic [LAT_W-1:0] LatOne = LAT_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StLaunch,
      StRun
   } state_e;

   state_e            state;
   logic [NumBtn-1:0] btn_raw;
   logic [NumBtn-1:0] sync_a;
   logic [NumBtn-1:0] sync_b;
   logic [NumBtn-1:0] db_level;
   logic [NumBtn-1:0] db_prev;
   logic [NumBtn-1:0] press;
   logic [7:0]        db_cnt [NumBtn];
   logic [LAT_W-1:0]  lat_cnt;
   logic [LAT_W-1:0]  lat_inc;
   logic [LAT_W-1:0]  lat_led;
   logic              class_led;

   assign btn_raw = {btn_toggle_k, btn_start, btn_load_y, btn_load_x};

   // Two-flop synchronizers feeding saturating per-button debounce counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a  <= '0;
         sync_b  <= '0;
         db_prev <= '0;
         for (int i = 0; i < NumBtn; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync_a  <= btn_raw;
         sync_b  <= sync_a;
         db_prev <= db_level;
         for (int i = 0; i < NumBtn; i++) begin
            if (!sync_b[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] < DbMax) begin
               db_cnt[i] <= db_cnt[i] + 8'd1;
            end
         end
      end
   end

   // Level drops on the first low sample, not when the counter clears a cycle later.
   always_comb begin
      db_level = '0;
      for (int i = 0; i < NumBtn; i++) begin
         db_level[i] = sync_b[i] && (db_cnt[i] == DbMax);
      end
   end

   assign press   = db_level & ~db_prev;
   assign lat_inc = (lat_cnt == LatMax) ? lat_cnt : lat_cnt + LatOne;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= StIdle;
         query_x   <= '0;
         query_y   <= '0;
         k_sel     <= 1'b0;
         eng_start <= 1'b0;
         busy      <= 1'b0;
         lat_cnt   <= '0;
         lat_led   <= '0;
         class_led <= 1'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (press[BtnLdX]) query_x <= switches;
               if (press[BtnLdY]) query_y <= switches;
               if (press[BtnTgK]) k_sel <= ~k_sel;
               if (press[BtnSt]) begin
                  lat_cnt   <= '0;
                  eng_start <= 1'b1;
                  busy      <= 1'b1;
                  state     <= StLaunch;
               end
            end
            StLaunch: begin
               lat_cnt <= lat_inc;
               if (!eng_done) begin
                  eng_start <= 1'b0;
                  state     <= StRun;
               end
            end
            StRun: begin
               lat_cnt <= lat_inc;
               if (eng_done) begin
                  class_led <= eng_class;
                  lat_led   <= lat_inc;
                  busy      <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               eng_start <= 1'b0;
               busy      <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

   assign leds = {lat_led, k_sel, class_led};

endmodule

// File: tb/tb_knn_panel_ctrl.sv
// Bench for knn_panel_ctrl: directed button presses against a simple engine model; completed runs
// are checked by a monitor against a queue of expected results.
module tb_knn_panel_ctrl;

   localparam int LdX = 0;
   localparam int LdY = 1;
   localparam int St  = 2;
   localparam int TgK = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] switches = 8'h00;
   logic       btn_load_x = 1'b0;
   logic       btn_load_y = 1'b0;
   logic       btn_start = 1'b0;
   logic       btn_toggle_k = 1'b0;
   logic [7:0] query_x;
   logic [7:0] query_y;
   logic       k_sel;
   logic       eng_start;
   logic       eng_done;
   logic       eng_class;
   logic       busy;
   logic [7:0] leds;

   int tests = 0;
   int fails = 0;

   knn_panel_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .LAT_W          (6)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .switches    (switches),
      .btn_load_x  (btn_load_x),
      .btn_load_y  (btn_load_y),
      .btn_start   (btn_start),
      .btn_toggle_k(btn_toggle_k),
      .query_x     (query_x),
      .query_y     (query_y),
      .k_sel       (k_sel),
      .eng_start   (eng_start),
      .eng_done    (eng_done),
      .eng_class   (eng_class),
      .busy        (busy),
      .leds        (leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Engine model: drops done one cycle after seeing start, raises it run_len cycles later.
   int   run_len = 20;
   logic next_class = 1'b0;
   logic eng_active;
   int   eng_cnt;

   always @(posedge clk) begin
      if (reset) begin
         eng_done   <= 1'b1;
         eng_class  <= 1'b0;
         eng_active <= 1'b0;
         eng_cnt    <= 0;
      end else if (!eng_active) begin
         if (eng_start && eng_done) begin
            eng_done   <= 1'b0;
            eng_active <= 1'b1;
            eng_cnt    <= 0;
         end
      end else begin
         eng_cnt <= eng_cnt + 1;
         if (eng_cnt + 1 == run_len) begin
            eng_done   <= 1'b1;
            eng_class  <= next_class;
            eng_active <= 1'b0;
         end
      end
   end

   typedef struct {
      logic       cls;
      int         lat;
      logic [7:0] qx;
      logic [7:0] qy;
      logic       k;
      int         start_w;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   task automatic push_exp(input logic cls, input int lat, input logic [7:0] qx,
                           input logic [7:0] qy, input logic k);
      exp_t e;
      e.cls     = cls;
      e.lat     = lat;
      e.qx      = qx;
      e.qy      = qy;
      e.k       = k;
      e.start_w = 2;
      exp_q.push_back(e);
   endtask

   // Monitor: a busy falling edge not caused by reset is a completed run.
   logic busy_prev = 1'b0;
   logic start_prev = 1'b0;
   logic rst_seen = 1'b0;
   int   start_w = 0;
   int   launches = 0;

   always @(posedge clk) rst_seen <= reset;

   always @(negedge clk) begin
      if (busy && !busy_prev) start_w = 0;
      if (eng_start) start_w++;
      if (eng_start && !start_prev) launches++;
      if (busy_prev && !busy && !rst_seen) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL run_unexpected: completion with empty scoreboard (t=%0t)", $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("run_class", int'(leds[0]), int'(mon_e.cls));
            check("run_latency", int'(leds[7:2]), mon_e.lat);
            check("run_k_led", int'(leds[1]), int'(mon_e.k));
            check("run_query_x", int'(query_x), int'(mon_e.qx));
            check("run_query_y", int'(query_y), int'(mon_e.qy));
            check("run_start_width", start_w, mon_e.start_w);
         end
      end
      busy_prev  = busy;
      start_prev = eng_start;
   end

   task automatic set_btn(input int which, input logic v);
      case (which)
         LdX:     btn_load_x = v;
         LdY:     btn_load_y = v;
         St:      btn_start = v;
         default: btn_toggle_k = v;
      endcase
   endtask

   task automatic press(input int which, input int hold);
      set_btn(which, 1'b1);
      repeat (hold) @(posedge clk);
      #1;
      set_btn(which, 1'b0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (busy && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (busy) begin
         tests++;
         fails++;
         $display("FAIL %s: busy still high after %0d cycles", name, n);
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_query_x", int'(query_x), 0);
      check("rst_query_y", int'(query_y), 0);
      check("rst_k_sel", int'(k_sel), 0);
      check("rst_eng_start", int'(eng_start), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_leds", int'(leds), 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Load and run, K=3
      switches = 8'h12;
      press(LdX, 8);
      check("load_x", int'(query_x), 'h12);
      switches = 8'h0F;
      press(LdY, 8);
      check("load_y", int'(query_y), 'h0F);
      check("k_sel_default", int'(k_sel), 0);
      run_len    = 20;
      next_class = 1'b1;
      push_exp(1'b1, 22, 8'h12, 8'h0F, 1'b0);
      btn_start = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      check("press_latency_before", int'(eng_start), 0);
      @(posedge clk);
      #1;
      check("press_latency_edge", int'(eng_start), 1);
      check("busy_on_launch", int'(busy), 1);
      repeat (3) @(posedge clk);
      #1;
      btn_start = 1'b0;
      wait_idle("run1");
      check("launches_run1", launches, 1);

      // Toggle and rerun
      press(TgK, 8);
      check("toggle_k", int'(k_sel), 1);
      check("toggle_led", int'(leds[1]), 1);
      check("toggle_no_start", int'(eng_start), 0);
      run_len    = 10;
      next_class = 1'b0;
      push_exp(1'b0, 12, 8'h12, 8'h0F, 1'b1);
      press(St, 8);
      wait_idle("run2");
      check("launches_run2", launches, 2);

      // Busy lockout
      run_len    = 60;
      next_class = 1'b1;
      push_exp(1'b1, 62, 8'h12, 8'h0F, 1'b1);
      press(St, 8);
      switches = 8'hF0;
      press(LdX, 8);
      press(TgK, 8);
      press(St, 8);
      check("lockout_busy", int'(busy), 1);
      check("lockout_query_x", int'(query_x), 'h12);
      check("lockout_k_sel", int'(k_sel), 1);
      wait_idle("run3");
      repeat (10) @(posedge clk);
      #1;
      check("lockout_launches", launches, 3);
      check("lockout_query_x_after", int'(query_x), 'h12);
      check("lockout_k_sel_after", int'(k_sel), 1);

      // Debounce: short glitch ignored, steady hold launches once
      btn_start = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      btn_start = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("glitch_launches", launches, 3);
      check("glitch_busy", int'(busy), 0);
      run_len    = 5;
      next_class = 1'b0;
      push_exp(1'b0, 7, 8'h12, 8'h0F, 1'b1);
      press(St, 10);
      wait_idle("run4");
      repeat (5) @(posedge clk);
      #1;
      check("hold_launches", launches, 4);

      // Latency saturation
      run_len    = 100;
      next_class = 1'b1;
      push_exp(1'b1, 63, 8'h12, 8'h0F, 1'b1);
      press(St, 8);
      wait_idle("run5");
      check("sat_leds", int'(leds), 'hFF);
      check("sat_launches", launches, 5);

      // Reset mid-run
      run_len    = 30;
      next_class = 1'b0;
      press(St, 8);
      check("midrun_busy", int'(busy), 1);
      check("midrun_in_run", int'(eng_start), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("midrst_eng_start", int'(eng_start), 0);
      check("midrst_busy", int'(busy), 0);
      check("midrst_leds", int'(leds), 0);
      check("midrst_query_x", int'(query_x), 0);
      repeat (2) @(posedge clk);
      #1;
      run_len    = 10;
      next_class = 1'b1;
      push_exp(1'b1, 12, 8'h00, 8'h00, 1'b0);
      press(St, 8);
      wait_idle("run7");
      check("post_reset_launches", launches, 7);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
